// File: rtl/signed_divider.sv
// Iterative restoring divider: signed 16-bit dividend by signed 8-bit divisor,
// start/busy/done handshake, truncating quotient, remainder follows dividend sign.
module signed_divider (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] dvd_q, dvd_d;      // dividend magnitude, shifted out as quotient shifts in
  logic [7:0]  dsr_q, dsr_d;
  logic [8:0]  prem_q, prem_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic        dz_pend_q, dz_pend_d;
  logic        done_q, done_d;
  logic [15:0] quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [9:0]  shifted;
  logic [9:0]  diff;

  assign shifted = {prem_q, dvd_q[15]};
  assign diff    = shifted - {2'b00, dsr_q};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    prem_d     = prem_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    ovf_pend_d = ovf_pend_q;
    dz_pend_d  = 1'b0;
    done_d     = 1'b0;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    // Divide-by-zero result lands one edge after acceptance without leaving IDLE.
    if (dz_pend_q) begin
      quot_d = 16'hFFFF;
      rem_d  = 8'h00;
      dbz_d  = 1'b1;
      ovf_d  = 1'b0;
      done_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == 8'h00) begin
            dz_pend_d = 1'b1;
          end else begin
            dvd_d      = dividend[15] ? 16'(-dividend) : dividend;
            dsr_d      = divisor[7] ? 8'(-divisor) : divisor;
            sign_a_d   = dividend[15];
            sign_b_d   = divisor[7];
            ovf_pend_d = (dividend == 16'h8000) && (divisor == 8'hFF);
            prem_d     = 9'd0;
            count_d    = 4'd0;
            state_d    = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (diff[9]) begin
          prem_d = shifted[8:0];
          dvd_d  = {dvd_q[14:0], 1'b0};
        end else begin
          prem_d = diff[8:0];
          dvd_d  = {dvd_q[14:0], 1'b1};
        end
        count_d = count_q + 4'd1;
        if (count_q == 4'd15) state_d = S_FIX;
      end
      S_FIX: begin
        quot_d  = (sign_a_q ^ sign_b_q) ? 16'(-dvd_q) : dvd_q;
        rem_d   = sign_a_q ? 8'(-prem_q[7:0]) : prem_q[7:0];
        dbz_d   = 1'b0;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      count_q    <= 4'd0;
      dvd_q      <= 16'd0;
      dsr_q      <= 8'd0;
      prem_q     <= 9'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      ovf_pend_q <= 1'b0;
      dz_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= 16'd0;
      rem_q      <= 8'd0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      prem_q     <= prem_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      ovf_pend_q <= ovf_pend_d;
      dz_pend_q  <= dz_pend_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// Bench for signed_divider: directed corner cases, handshake timing, reset abort,
// random operands against an integer-arithmetic model, and multiply/divide round trips.
module tb_signed_divider;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero, overflow;

  int n_chk  = 0;
  int n_fail = 0;

  signed_divider dut (
    .CLK(CLK), .RST(RST), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating signed division in plain integer arithmetic.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic dz, output logic ov);
    int ai, bi;
    ai = $signed(a);
    bi = $signed(b);
    dz = 1'b0; ov = 1'b0;
    if (bi == 0) begin
      q = 16'hFFFF; r = 8'h00; dz = 1'b1;
    end else begin
      q  = 16'(ai / bi);
      r  = 8'(ai % bi);
      ov = (ai == -32768) && (bi == -1);
    end
  endtask

  // Counts edges until done is seen; busy must equal exp_busy on every earlier edge.
  task automatic wait_done(input logic exp_busy, output int lat, output int busy_bad);
    lat = 99; busy_bad = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge CLK); #1;
      if (done) begin
        lat = j;
        if (busy) busy_bad++;
        break;
      end
      if (busy !== exp_busy) busy_bad++;
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input string tag);
    logic [15:0] eq; logic [7:0] er; logic edz, eov;
    int lat, bb;
    ref_div(a, b, eq, er, edz, eov);
    @(negedge CLK);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge CLK); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
    chk({tag, "_busy_k"}, 32'(busy), 32'(b != 8'h00));
    wait_done(b != 8'h00, lat, bb);
    chk({tag, "_lat"}, lat, (b == 8'h00) ? 1 : 17);
    chk({tag, "_busy"}, bb, 0);
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_flags"}, {30'd0, div_by_zero, overflow}, {30'd0, edz, eov});
  endtask

  logic [15:0] dir_a [12] = '{16'h03E8, 16'hFC18, 16'h03E8, 16'hFC18, 16'h8000, 16'h8000,
                              16'h7FFF, 16'h1234, 16'h0010, 16'h0000, 16'hFFFF, 16'h7FFF};
  logic [7:0]  dir_b [12] = '{8'h07, 8'h07, 8'hF9, 8'hF9, 8'hFF, 8'h80,
                              8'h80, 8'h00, 8'h04, 8'h05, 8'h01, 8'h01};

  initial begin
    int lat, bb, nd;
    logic [7:0] ra, rb;
    logic [15:0] prod;

    RST = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", {busy, done, quotient, remainder, div_by_zero, overflow}, 32'd0);
    RST = 1'b0;

    // Spot-check the model against hand-computed values before trusting it.
    do_op(16'h03E8, 8'h07, "d1000_7");
    chk("abs_q", 32'(quotient), 32'h008E);
    chk("abs_r", 32'(remainder), 32'h06);
    do_op(16'h8000, 8'hFF, "ovf");
    chk("abs_ovf", {quotient, 7'd0, overflow}, {16'h8000, 8'h01});
    do_op(16'h7FFF, 8'h80, "max_min");
    chk("abs_mm", {quotient, remainder}, {16'hFF01, 8'h7F});

    for (int i = 0; i < 12; i++) do_op(dir_a[i], dir_b[i], $sformatf("dir%0d", i));

    // A start pulse during CALC must not disturb the running operation.
    @(negedge CLK);
    start = 1'b1; dividend = 16'h03E8; divisor = 8'h07;
    @(posedge CLK); #1; start = 1'b0;
    repeat (5) @(posedge CLK);
    #1; start = 1'b1; dividend = 16'h1111; divisor = 8'h03;
    @(posedge CLK); #1; start = 1'b0;
    wait_done(1'b1, lat, bb);
    chk("ign_lat", lat, 11);
    chk("ign_res", {quotient, remainder}, {16'h008E, 8'h06});

    // Synchronous reset mid-CALC aborts with cleared outputs and no done.
    @(negedge CLK);
    start = 1'b1; dividend = 16'h03E8; divisor = 8'h07;
    @(posedge CLK); #1; start = 1'b0;
    repeat (8) @(posedge CLK);
    #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    chk("rst_mid", {busy, done, quotient, remainder, div_by_zero, overflow}, 32'd0);
    nd = 0;
    repeat (25) begin
      @(posedge CLK); #1;
      if (done || busy) nd++;
    end
    chk("rst_quiet", nd, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      do_op(16'($urandom), b, $sformatf("rnd%0d", i));
    end

    // Round trip through a multiply: (a*b)/b returns a with zero remainder.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      do rb = 8'($urandom); while (rb == 8'h00 || rb == 8'hFF);
      prod = 16'($signed(ra) * $signed(rb));
      do_op(prod, rb, $sformatf("rt%0d", i));
      chk($sformatf("rt%0d_a", i), {quotient, remainder}, {{8{ra[7]}}, ra, 8'h00});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
